imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the RISC-V decode stage; next generation of the
//  combinational extender. Explicit 3-bit format code (no opcode-bit sniffing), XLEN-generic sign
//  extension, shift-amount format, 1..3 register stages with valid/ready handshake, flush and tag
//  passthrough (PC/rd) so the result stays aligned with its instruction.
// PARAMETERS
//  XLEN    32  result width; 32 or 64 only; other values are a compile-time error
//  STAGES  1   register stages between input and output, 1..3
//  TAG_W   8   width of sideband tag carried unchanged alongside each immediate
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous active-high reset
//  in_valid   in   1       instruction/format pair valid
//  in_ready   out  1       stage 0 can accept this cycle
//  in_instr   in   32      raw instruction word
//  in_fmt     in   3       format code (imm_pkg::IMM_*)
//  in_tag     in   TAG_W   sideband tag
//  flush      in   1       squash all in-flight entries
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_imm    out  XLEN    extended immediate
//  out_tag    out  TAG_W   tag of out_imm
//  out_illeg  out  1       format code was illegal/unsupported (out_imm = 0)
// BEHAVIOUR
//  Formats (sx = sign-extend to XLEN from instr[31]):
//   000 I: sx(instr[31:20]); 001 S: sx({[31:25],[11:7]}); 010 B: sx({[31],[7],[30:25],[11:8],0})
//   011 U: sx({[31:12],12'b0}) (sign-extended above bit 31 when XLEN=64)
//   100 J: sx({[31],[19:12],[20],[30:21],0})
//   101 SHAMT: zero-ext instr[24:20] (XLEN=32) / instr[25:20] (XLEN=64)
//   110 ZIMM: see CONFIGURATION; 111: illegal -> out_imm=0, out_illeg=1
//  Decode is combinational ahead of stage 0; latency = STAGES cycles from accepted input to out_valid.
//  Stage k holds valid_k; it loads when !valid_k or stage k+1 loads (last stage: out_ready).
//  in_ready = !valid_0 | stage 1 loads; full throughput 1/cycle with out_ready held high.
//  Handshake: out_imm/out_tag/out_illeg stable while out_valid & !out_ready; no drop, no duplicate.
//  flush: all valid_k <= 0 next edge; input offered same cycle is discarded; flush wins over accept.
//  rst: all valid_k, out_imm, out_tag, out_illeg = 0 immediately; in_ready = 1 after release.
//  Data regs load only on accept (no toggling on bubbles).
// CONFIGURATION
//  IMM_ZIMM_EN defined: fmt 110 = CSR zimm, zero-ext instr[19:15], out_illeg=0.
//  IMM_ZIMM_EN undefined: fmt 110 treated as illegal (out_imm=0, out_illeg=1).
// STRUCTURE
//  imm_pkg: localparams IMM_I..IMM_ILL (3-bit codes), XLEN legality check helper.
//  Sub-module imm_decode: combinational fmt+instr -> {imm, illeg}; generate-loop of STAGES regs in top.
// TESTING
//  1 I: instr 0xFFF00093 fmt 000 -> out_imm 0xFFFFFFFF after STAGES cycles, out_illeg 0.
//  2 S/B/U/J: 0xFE20AE23/001 -> 0xFFFFFFFC; 0xFE000EE3/010 -> 0xFFFFFFFC;
//    0x123450B7/011 -> 0x12345000; 0x001000EF/100 -> 0x00000800; XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000.
//  3 Backpressure: STAGES=3, 5 back-to-back inputs, out_ready=0 cycles 2..6 -> in_ready low after 3
//    accepted, outputs in order with correct tags, none lost or repeated.
//  4 Flush: 2 entries in flight, flush=1 with in_valid=1 -> out_valid 0 next cycle, offered input dropped.
//  5 Formats 110/111: with and without IMM_ZIMM_EN; instr 0x000F5073 fmt 110 -> 0x1E or illeg=1/imm=0.
//  6 Reset asserted mid-stream (async, off clock edge) -> out_valid/out_imm 0 at once; resumes cleanly.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Format codes and parameter legality helper shared by the immediate generator pipeline.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_ILL   = 3'b111;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input/output handshake bundle of the immediate generator; master drives requests, slave is the pipe.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [2:0]        in_fmt;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illeg;

  modport master (
    output in_valid, in_instr, in_fmt, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illeg
  );

  modport slave (
    input  in_valid, in_instr, in_fmt, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illeg
  );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational format-code driven immediate extraction and XLEN sign extension.
// Macro IMM_ZIMM_EN enables the CSR zimm format (code 110); otherwise that code is illegal.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fmt,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            illeg
);

  // Every format is first built as a sign-correct 32-bit value, then widened once.
  logic signed [31:0] raw;

  always_comb begin
    raw   = '0;
    illeg = 1'b0;
    case (fmt)
      IMM_I:     raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     raw = {instr[31:12], 12'b0};
      IMM_J:     raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
`ifdef IMM_ZIMM_EN
      IMM_ZIMM:  raw = {27'b0, instr[19:15]};
`else
      IMM_ZIMM:  illeg = 1'b1;
`endif
      default:   illeg = 1'b1;
    endcase
  end

  assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode ahead of STAGES valid/ready register stages with flush and tag.
// Macro IMM_ZIMM_EN (see imm_decode) selects whether format 110 yields a CSR zimm or is illegal.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  imm_gen_pipe_if.slave bus
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("imm_gen_pipe: STAGES must be 1..3");
  end

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illeg;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .fmt   (bus.in_fmt),
    .instr (bus.in_instr),
    .imm   (dec_imm),
    .illeg (dec_illeg)
  );

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] illeg_q;
  logic [XLEN-1:0]   imm_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_illeg;
  logic [XLEN-1:0]   src_imm [STAGES];
  logic [TAG_W-1:0]  src_tag [STAGES];

  // load[k]: stage k captures this cycle; load[STAGES] is the consumer taking the result.
  logic [STAGES:0] load;

  always_comb begin
    load         = '0;
    load[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || load[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid[k] = bus.in_valid;
      assign src_illeg[k] = dec_illeg;
      assign src_imm[k]   = dec_imm;
      assign src_tag[k]   = bus.in_tag;
    end else begin : g_body
      assign src_valid[k] = valid_q[k-1];
      assign src_illeg[k] = illeg_q[k-1];
      assign src_imm[k]   = imm_q[k-1];
      assign src_tag[k]   = tag_q[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        illeg_q[k] <= 1'b0;
        imm_q[k]   <= '0;
        tag_q[k]   <= '0;
      end else begin
        if (bus.flush) begin
          valid_q[k] <= 1'b0;
        end else if (load[k]) begin
          valid_q[k] <= src_valid[k];
        end
        // Data only moves with a real entry so bubbles leave the registers quiet.
        if (!bus.flush && load[k] && src_valid[k]) begin
          illeg_q[k] <= src_illeg[k];
          imm_q[k]   <= src_imm[k];
          tag_q[k]   <= src_tag[k];
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_illeg = illeg_q[STAGES-1];
  assign bus.out_imm   = imm_q[STAGES-1];
  assign bus.out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 3-stage XLEN=32 instance plus a 1-stage XLEN=64 instance.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int STAGES = 3;
  localparam int TAG_W  = 8;

  typedef struct {
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             illeg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(TAG_W)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_out = 0;
  exp_t q[$];
  exp_t pend;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: records accepted inputs and compares results in order; also checks hold under stall.
  initial begin
    exp_t             e;
    logic             held;
    logic [31:0]      h_imm;
    logic [TAG_W-1:0] h_tag;
    logic             h_illeg;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && bus.out_valid) begin
          check_val("hold_imm", bus.out_imm, h_imm);
          check_val("hold_tag", bus.out_tag, h_tag);
          check_val("hold_illeg", bus.out_illeg, h_illeg);
        end
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (q.size() > 0) begin
            e = q.pop_front();
            check_val("out_imm", bus.out_imm, e.imm);
            check_val("out_tag", bus.out_tag, e.tag);
            check_val("out_illeg", bus.out_illeg, e.illeg);
          end
        end
        if (bus.flush) begin
          n_acc -= q.size();
          q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
          q.push_back(pend);
          n_acc++;
        end
        held    = bus.out_valid && !bus.out_ready;
        h_imm   = bus.out_imm;
        h_tag   = bus.out_tag;
        h_illeg = bus.out_illeg;
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [2:0] fmt, input logic [TAG_W-1:0] tag,
                      input logic [31:0] eimm, input logic eill);
    bit done;
    done = 1'b0;
    pend = '{eimm, tag, eill};
    bus.in_instr = instr;
    bus.in_fmt   = fmt;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      done = bus.in_ready;
    end
    if (!done) check_val("send_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 40 && n_out != n_acc; n++) @(posedge clk);
    repeat (3) @(negedge clk);
    check_val("drain_count", n_out, n_acc);
    check_val("drain_idle", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send64(input logic [31:0] instr, input logic [2:0] fmt, input string tag,
                        input logic [63:0] eimm);
    bus64.in_instr = instr;
    bus64.in_fmt   = fmt;
    bus64.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    check_val({tag, "_valid"}, bus64.out_valid, 1);
    check_val({tag, "_imm"}, bus64.out_imm, eimm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int acc0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_fmt     = '0;
    bus.in_tag     = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.in_instr  = '0;
    bus64.in_fmt    = '0;
    bus64.in_tag    = 8'h64;
    bus64.flush     = 1'b0;
    bus64.out_ready = 1'b1;

    #2;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_imm", bus.out_imm, 0);
    check_val("rst_out_tag", bus.out_tag, 0);
    check_val("rst_out_illeg", bus.out_illeg, 0);
    check_val("rst64_out_valid", bus64.out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Latency with the consumer always ready
    send(32'hFFF00093, IMM_I, 8'h01, 32'hFFFFFFFF, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", lat, STAGES);
    drain();

    // All formats back to back
    send(32'hFE20AE23, IMM_S,     8'h02, 32'hFFFFFFFC, 1'b0);
    send(32'hFE000EE3, IMM_B,     8'h03, 32'hFFFFFFFC, 1'b0);
    send(32'h123450B7, IMM_U,     8'h04, 32'h12345000, 1'b0);
    send(32'h001000EF, IMM_J,     8'h05, 32'h00000800, 1'b0);
    send(32'h00500093, IMM_I,     8'h06, 32'h00000005, 1'b0);
    send(32'h41F0D093, IMM_SHAMT, 8'h07, 32'h0000001F, 1'b0);
    send(32'hFFFFFFFF, IMM_ILL,   8'h08, 32'h00000000, 1'b1);
`ifdef IMM_ZIMM_EN
    send(32'h000F5073, IMM_ZIMM,  8'h09, 32'h0000001E, 1'b0);
`else
    send(32'h000F5073, IMM_ZIMM,  8'h09, 32'h00000000, 1'b1);
`endif
    drain();

    // Backpressure: fill three stages, stall, then release
    acc0 = n_acc;
    bus.out_ready = 1'b0;
    send(32'h00100093, IMM_I, 8'h21, 32'h1, 1'b0);
    send(32'h00200093, IMM_I, 8'h22, 32'h2, 1'b0);
    send(32'h00300093, IMM_I, 8'h23, 32'h3, 1'b0);
    @(negedge clk);
    check_val("bp_in_ready_full", bus.in_ready, 0);
    check_val("bp_out_valid", bus.out_valid, 1);
    fork
      begin
        send(32'h00400093, IMM_I, 8'h24, 32'h4, 1'b0);
        send(32'h00500093, IMM_I, 8'h25, 32'h5, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    check_val("bp_accepted", n_acc - acc0, 5);
    drain();

    // Flush with entries in flight and an input offered the same cycle
    bus.out_ready = 1'b0;
    send(32'h00A00093, IMM_I, 8'h31, 32'hA, 1'b0);
    send(32'h00B00093, IMM_I, 8'h32, 32'hB, 1'b0);
    @(posedge clk);
    #1;
    check_val("pre_flush_valid", bus.out_valid, 1);
    pend = '{32'h7, 8'h33, 1'b0};
    bus.in_instr = 32'h00700093;
    bus.in_fmt   = IMM_I;
    bus.in_tag   = 8'h33;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_val("flush_out_valid", bus.out_valid, 0);
    check_val("flush_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("flush_no_out", bus.out_valid, 0);
    check_val("flush_count", n_out, n_acc);

    // Asynchronous reset in the middle of a stream
    bus.out_ready = 1'b0;
    send(32'hFFF00093, IMM_I, 8'h41, 32'hFFFFFFFF, 1'b0);
    send(32'hFE20AE23, IMM_S, 8'h42, 32'hFFFFFFFC, 1'b0);
    @(posedge clk);
    #1;
    check_val("pre_arst_valid", bus.out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check_val("arst_out_valid", bus.out_valid, 0);
    check_val("arst_out_imm", bus.out_imm, 0);
    check_val("arst_out_tag", bus.out_tag, 0);
    q.delete();
    n_acc = n_out;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_val("arst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(32'h001000EF, IMM_J, 8'h43, 32'h00000800, 1'b0);
    drain();

    // XLEN=64 instance
    send64(32'h800000B7, IMM_U,     "x64_u",     64'hFFFFFFFF80000000);
    send64(32'hFFF00093, IMM_I,     "x64_i",     64'hFFFFFFFFFFFFFFFF);
    send64(32'h03F0D093, IMM_SHAMT, "x64_shamt", 64'h000000000000003F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
